mm_stream_driver: RTL and testbench

//  Host-side driver for the `main` systolic matmul stream interface. Holds MxM int8

---
 rtl/mm_pkg.sv | 22 ++
 rtl/mm_elem_seq.sv | 49 ++++
 rtl/mm_stream_driver.sv | 177 +++++++++++++++++
 tb/tb_mm_stream_driver.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and helpers for the matmul stream driver and its element sequencer.
package mm_pkg;

    typedef logic signed [7:0]  elem_t;
    typedef logic signed [15:0] acc_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        STREAM,
        DRAIN,
        DONE
    } drv_state_t;

    localparam int unsigned MDefault = 3;

    // Address width of an m x m row-major store; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned m);
        return (m * m > 1) ? $clog2(m * m) : 1;
    endfunction

endpackage

// File: rtl/mm_elem_seq.sv
// Skewed k-major element sequencer: beat n = k*M+i, k outer, i inner.
// o_beat doubles as the B[k][i] row-major address; o_a_addr is A[i][k].
module mm_elem_seq
    import mm_pkg::*;
#(
    parameter int unsigned M = MDefault,
    localparam int unsigned AW = addr_w(M)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [AW-1:0] o_beat,
    output logic [AW-1:0] o_a_addr,
    output logic          o_last
);

    localparam int unsigned   KW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [KW-1:0] KMax = KW'(M - 1);

    logic [KW-1:0] r_k;
    logic [KW-1:0] r_i;

    // Nested k/i counters; wrap back to beat 0 after the last beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k <= '0;
            r_i <= '0;
        end else if (i_clr) begin
            r_k <= '0;
            r_i <= '0;
        end else if (i_adv) begin
            if (r_i == KMax) begin
                r_i <= '0;
                r_k <= (r_k == KMax) ? '0 : r_k + KW'(1);
            end else begin
                r_i <= r_i + KW'(1);
            end
        end
    end

    // Beat index, A address and last-beat flag for the current position
    always_comb begin
        o_beat   = AW'(32'(r_k) * M + 32'(r_i));
        o_a_addr = AW'(32'(r_i) * M + 32'(r_k));
        o_last   = (r_k == KMax) && (r_i == KMax);
    end

endmodule

// File: rtl/mm_stream_driver.sv
// Host-side driver for the systolic matmul array: holds A/B operands, streams them
// skewed k-major, captures the row-major result stream and flags completion.
module mm_stream_driver
    import mm_pkg::*;
#(
    parameter int unsigned M       = MDefault,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned AW     = addr_w(M)
) (
    input  logic          CLK,
    input  logic          rstb,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  elem_t         wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] rd_addr,
    output acc_t          rd_data,
    output elem_t         a_out,
    output elem_t         b_out,
    output logic          frm_n,
    input  logic          arr_rdy,
    input  acc_t          c_in,
    input  logic          c_vld,
    output logic          c_rdy
);

    localparam int unsigned   NEl     = M * M;
    localparam logic [AW:0]   NumEl   = (AW + 1)'(NEl);
    localparam int unsigned   IW      = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IdleMax = IW'(TIMEOUT - 1);

    elem_t r_a_mem [NEl];
    elem_t r_b_mem [NEl];
    acc_t  r_c_mem [NEl];

    drv_state_t    r_state;
    drv_state_t    w_state_nxt;
    logic [AW:0]   r_cnt;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_idle_nxt;
    logic          r_err;
    logic          r_frm_n;
    logic          r_last_loaded;
    elem_t         r_a_out;
    elem_t         r_b_out;

    logic          w_start_acc;
    logic          w_wr_acc;
    logic          w_cap_beat;
    logic          w_cap_wr;
    logic          w_ovf;
    logic          w_load;
    logic          w_stream_end;
    logic          w_timeout;
    logic [AW-1:0] w_seq_beat;
    logic [AW-1:0] w_seq_a_addr;
    logic          w_seq_last;

    mm_elem_seq #(
        .M(M)
    ) u_seq (
        .i_clk   (CLK),
        .i_rst_n (rstb),
        .i_clr   (w_start_acc),
        .i_adv   (w_load),
        .o_beat  (w_seq_beat),
        .o_a_addr(w_seq_a_addr),
        .o_last  (w_seq_last)
    );

    // Next-state, handshake decode and state-derived outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_idle_nxt   = '0;
        w_timeout    = 1'b0;
        c_rdy        = (r_state == STREAM) || (r_state == DRAIN);
        busy         = (r_state != IDLE);
        done         = (r_state == DONE);
        w_start_acc  = (r_state == IDLE) && start;
        w_wr_acc     = (r_state == IDLE) && wr_en && ({1'b0, wr_addr} < NumEl);
        w_cap_beat   = c_vld && c_rdy;
        w_cap_wr     = w_cap_beat && (r_cnt != NumEl);
        w_ovf        = w_cap_beat && (r_cnt == NumEl);
        // Load the next pair on entry to STREAM and every STREAM cycle until the last
        w_load       = ((r_state == WAIT_RDY) && arr_rdy) ||
                       ((r_state == STREAM) && !r_last_loaded);
        w_stream_end = (r_state == STREAM) && r_last_loaded;
        if ((r_state == DRAIN) && !w_cap_beat) begin
            w_idle_nxt = r_idle + IW'(1);
            w_timeout  = (r_idle == IdleMax) && (r_cnt != NumEl);
        end
        case (r_state)
            IDLE:     if (start)                          w_state_nxt = WAIT_RDY;
            WAIT_RDY: if (arr_rdy)                        w_state_nxt = STREAM;
            STREAM:   if (r_last_loaded)                  w_state_nxt = DRAIN;
            DRAIN:    if ((r_cnt == NumEl) || w_timeout)  w_state_nxt = DONE;
            DONE:                                         w_state_nxt = IDLE;
            default:                                      w_state_nxt = IDLE;
        endcase
    end

    // FSM state, capture count, drain idle count and sticky error
    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
            r_idle  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= w_idle_nxt;
            if (w_start_acc) begin
                r_cnt <= '0;
            end else if (w_cap_wr) begin
                r_cnt <= r_cnt + (AW + 1)'(1);
            end
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_timeout || w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    // Registered stream outputs: one pair per STREAM cycle, idle values after the last
    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            r_frm_n       <= 1'b1;
            r_a_out       <= '0;
            r_b_out       <= '0;
            r_last_loaded <= 1'b0;
        end else if (w_load) begin
            r_frm_n       <= 1'b0;
            r_a_out       <= r_a_mem[w_seq_a_addr];
            r_b_out       <= r_b_mem[w_seq_beat];
            r_last_loaded <= w_seq_last;
        end else if (w_stream_end) begin
            r_frm_n       <= 1'b1;
            r_a_out       <= '0;
            r_b_out       <= '0;
            r_last_loaded <= 1'b0;
        end
    end

    // Operand stores; only writable in IDLE so a frame sees frozen operands
    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            if (wr_sel) begin
                r_b_mem[wr_addr] <= wr_data;
            end else begin
                r_a_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Result store, filled row-major in arrival order
    always_ff @(posedge CLK) begin
        if (w_cap_wr) begin
            r_c_mem[r_cnt[AW-1:0]] <= c_in;
        end
    end

    // Combinational result read; out-of-range addresses read as zero
    always_comb begin
        rd_data = ({1'b0, rd_addr} < NumEl) ? r_c_mem[rd_addr] : '0;
    end

    assign err   = r_err;
    assign frm_n = r_frm_n;
    assign a_out = r_a_out;
    assign b_out = r_b_out;

endmodule

// File: tb/tb_mm_stream_driver.sv
// Self-checking bench: behavioural array model consumes the operand stream, forms C
// from it and returns C row-major; results are checked against a matrix product of
// the operands written by the host.
module tb_mm_stream_driver;

    localparam int M       = 3;
    localparam int NN      = M * M;
    localparam int TIMEOUT = 64;
    localparam int AW      = 4;

    logic                 CLK = 1'b0;
    logic                 rstb;
    logic                 wr_en;
    logic                 wr_sel;
    logic [AW-1:0]        wr_addr;
    logic signed [7:0]    wr_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [AW-1:0]        rd_addr;
    logic signed [15:0]   rd_data;
    logic signed [7:0]    a_out;
    logic signed [7:0]    b_out;
    logic                 frm_n;
    logic                 arr_rdy;
    logic signed [15:0]   c_in;
    logic                 c_vld;
    logic                 c_rdy;

    mm_stream_driver #(
        .M      (M),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK    (CLK),
        .rstb   (rstb),
        .wr_en  (wr_en),
        .wr_sel (wr_sel),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .a_out  (a_out),
        .b_out  (b_out),
        .frm_n  (frm_n),
        .arr_rdy(arr_rdy),
        .c_in   (c_in),
        .c_vld  (c_vld),
        .c_rdy  (c_rdy)
    );

    always #5 CLK = ~CLK;

    int checks       = 0;
    int failures     = 0;
    int cyc          = 0;
    int done_cnt     = 0;
    int done_cyc     = 0;
    int last_acc_cyc = 0;

    int a_m   [NN];
    int b_m   [NN];
    int c_gold[NN];
    int c_mod [NN];
    int a_cap [NN+2];
    int b_cap [NN+2];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic write_op(input bit sel, input int addr, input int val);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = 8'(val);
        @(negedge CLK);
        wr_en   = 1'b0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NN; i++) begin
            a_m[i] = int'($urandom_range(0, 200)) - 100;
            b_m[i] = int'($urandom_range(0, 200)) - 100;
        end
    endtask

    // Hold one result beat until the driver accepts it (bounded)
    task automatic send_beat(input int v, output bit ok);
        c_vld = 1'b1;
        c_in  = 16'(v);
        ok    = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (c_rdy) ok = 1'b1;
            @(negedge CLK);
        end
        if (ok) last_acc_cyc = cyc;
    endtask

    task automatic run_frame(input int gmin, input int gmax, input int n_emit,
                             input bit exp_err, input string name);
        int  snap;
        int  n;
        int  d;
        int  ncheck;
        bit  ok;
        bit  got;
        for (int i = 0; i < NN; i++) write_op(1'b0, i, a_m[i]);
        for (int i = 0; i < NN - 1; i++) write_op(1'b1, i, b_m[i]);
        // Last operand write lands in the same cycle as start
        wr_en   = 1'b1;
        wr_sel  = 1'b1;
        wr_addr = AW'(NN - 1);
        wr_data = 8'(b_m[NN-1]);
        start   = 1'b1;
        snap    = done_cnt;
        @(negedge CLK);
        wr_en = 1'b0;
        start = 1'b0;
        check_eq({name, "_busy_at_start"}, busy, 1);
        check_eq({name, "_err_cleared"}, err, 0);
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        arr_rdy = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge CLK);
            if (!frm_n) got = 1'b1;
        end
        if (!got) begin
            check_eq({name, "_stream_start"}, 0, 1);
            arr_rdy = 1'b0;
            return;
        end
        n = 0;
        while (!frm_n && n < NN + 2) begin
            a_cap[n] = a_out;
            b_cap[n] = b_out;
            n++;
            @(negedge CLK);
        end
        arr_rdy = 1'b0;
        check_eq({name, "_beats"}, n, NN);
        check_eq({name, "_a_tail"}, a_out, 0);
        check_eq({name, "_b_tail"}, b_out, 0);
        // Beat k*M+i carries A[i][k] and B[k][i]
        for (int k = 0; k < M; k++) begin
            for (int i = 0; i < M; i++) begin
                check_eq($sformatf("%s_a_beat%0d", name, k*M+i), a_cap[k*M+i], a_m[i*M+k]);
                check_eq($sformatf("%s_b_beat%0d", name, k*M+i), b_cap[k*M+i], b_m[k*M+i]);
            end
        end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                c_gold[i*M+j] = 0;
                c_mod[i*M+j]  = 0;
                for (int k = 0; k < M; k++) begin
                    c_gold[i*M+j] += a_m[i*M+k] * b_m[k*M+j];
                    c_mod[i*M+j]  += a_cap[k*M+i] * b_cap[k*M+j];
                end
            end
        end
        for (int e = 0; e < n_emit; e++) begin
            c_vld = 1'b0;
            repeat ($urandom_range(gmin, gmax)) @(negedge CLK);
            send_beat((e < NN) ? c_mod[e] : 32'h7abc, ok);
            if (e < NN) check_eq($sformatf("%s_c_acc%0d", name, e), ok, 1);
        end
        c_vld = 1'b0;
        got = 1'b0;
        for (int t = 0; t < TIMEOUT + 40 && !got; t++) begin
            if (done_cnt != snap) got = 1'b1;
            else @(negedge CLK);
        end
        check_eq({name, "_done_seen"}, got, 1);
        repeat (3) @(negedge CLK);
        check_eq({name, "_done_once"}, done_cnt - snap, 1);
        check_eq({name, "_err"}, err, exp_err);
        check_eq({name, "_busy_after"}, busy, 0);
        if (n_emit < NN) begin
            d = done_cyc - last_acc_cyc;
            check_eq({name, "_timeout_window"}, (d >= TIMEOUT && d <= TIMEOUT + 1), 1);
        end
        ncheck = (n_emit < NN) ? n_emit : NN;
        for (int e = 0; e < ncheck; e++) begin
            rd_addr = AW'(e);
            #1;
            check_eq($sformatf("%s_c%0d", name, e), rd_data, c_gold[e]);
        end
        rd_addr = '0;
        @(negedge CLK);
    endtask

    task automatic reset_mid_stream();
        int snap;
        bit got;
        rand_ops();
        for (int i = 0; i < NN; i++) write_op(1'b0, i, a_m[i]);
        for (int i = 0; i < NN; i++) write_op(1'b1, i, b_m[i]);
        snap    = done_cnt;
        start   = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
        arr_rdy = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge CLK);
            if (!frm_n) got = 1'b1;
        end
        check_eq("rst_stream_start", got, 1);
        repeat (4) @(negedge CLK);
        rstb = 1'b0;
        #1;
        check_eq("rst_frm_n", frm_n, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_c_rdy", c_rdy, 0);
        check_eq("rst_a_out", a_out, 0);
        arr_rdy = 1'b0;
        repeat (2) @(negedge CLK);
        rstb = 1'b1;
        repeat (4) @(negedge CLK);
        check_eq("rst_no_done", done_cnt - snap, 0);
        check_eq("rst_idle_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb    = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        rd_addr = '0;
        arr_rdy = 1'b0;
        c_in    = '0;
        c_vld   = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_frm_n", frm_n, 1);
        check_eq("reset_c_rdy", c_rdy, 0);
        check_eq("reset_a_out", a_out, 0);
        check_eq("reset_b_out", b_out, 0);
        rstb = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < NN; i++) begin
            a_m[i] = (i % (M + 1) == 0) ? 1 : 0;
            b_m[i] = a_m[i];
        end
        run_frame(0, 0, NN, 1'b0, "ident");

        a_m = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
        b_m = '{1, 0, 0, 0, 2, 0, 2, 0, 1};
        run_frame(0, 1, NN, 1'b0, "gen");
        check_eq("gen_c_spec0", c_gold[0], 1);
        check_eq("gen_c_spec1", c_gold[1], 2);
        check_eq("gen_c_spec6", c_gold[6], 2);

        rand_ops();
        run_frame(2, 2, NN, 1'b0, "gap");

        rand_ops();
        run_frame(0, 1, 4, 1'b1, "tmo");

        rand_ops();
        run_frame(0, 0, NN + 1, 1'b1, "ovf");

        rand_ops();
        run_frame(0, 2, NN, 1'b0, "clr");

        reset_mid_stream();
        rand_ops();
        run_frame(0, 1, NN, 1'b0, "rerun");

        for (int r = 0; r < 4; r++) begin
            rand_ops();
            run_frame(0, 3, NN, 1'b0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
